// File: rtl/spi_pkg.sv
// Shared SPI link constants: data width, responder state encoding and underrun fill byte.
// Pure declarations, no logic; imported by the peripheral and its helpers.
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_CNT_W  = $clog2(SPI_DATA_W);

    localparam logic [SPI_DATA_W-1:0] SPI_FILL_BYTE = 8'h00;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser with registered rise/fall strobes; strobe lags the pin by SYNC_STAGES+1 cycles.
// No backpressure: strobes are single-cycle pulses that the consumer must act on immediately.
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_peripheral.sv
// Oversampled mode-0 SPI responder; rx_valid lands SYNC_STAGES+2 cycles after the 8th SCLK rise, one-entry tx holding register.
// Tx backpressure via o_tx_ready (holding register empty); SPI_PERIPHERAL_STATUS_EN adds frame-error/underrun pulses.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    input  logic [SPI_DATA_W-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [SPI_DATA_W-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_busy
`ifdef SPI_PERIPHERAL_STATUS_EN
    ,
    output logic                  o_frame_err,
    output logic                  o_tx_underrun
`endif
);

    localparam int WARM   = SYNC_STAGES + 2;
    localparam int WARM_W = $clog2(WARM + 1);

    logic w_sclk_lvl_unused;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_lvl;
    logic w_cs_rise;
    logic w_cs_fall;

    spi_input_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_sclk),
        .o_level (w_sclk_lvl_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_input_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync_cs (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_cs_n),
        .o_level (w_cs_lvl),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // CS_n may still be low when reset releases; the synchroniser flushing its
    // reset value would fake a fall, so falls are ignored until the pipe has drained.
    logic [WARM_W-1:0] r_warm;
    logic              w_armed;

    assign w_armed = (r_warm == WARM_W'(WARM));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_warm <= '0;
        end else if (!w_armed) begin
            r_warm <= r_warm + WARM_W'(1);
        end
    end

    spi_state_t            r_state;
    logic [SPI_CNT_W-1:0]  r_bit_cnt;
    logic [SPI_DATA_W-1:0] r_rx_shift;
    logic [SPI_DATA_W-1:0] r_tx_shift;
    logic [SPI_DATA_W-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_miso;
    logic [SPI_DATA_W-1:0] r_hold;
    logic                  r_hold_full;
`ifdef SPI_PERIPHERAL_STATUS_EN
    logic                  r_frame_err;
    logic                  r_tx_underrun;
`endif

    logic                  w_load_start;
    logic                  w_load_next;
    logic                  w_reload;
    logic [SPI_DATA_W-1:0] w_reload_dat;
    logic [SPI_DATA_W-1:0] w_rx_next;
    logic                  w_tx_accept;

    assign w_load_start = (r_state == IDLE) && w_cs_fall && w_armed;
    assign w_load_next  = (r_state == ACTIVE) && !w_cs_rise && !w_sclk_rise &&
                          w_sclk_fall && (r_bit_cnt == '0);
    assign w_reload     = w_load_start || w_load_next;
    assign w_reload_dat = r_hold_full ? r_hold : SPI_FILL_BYTE;
    assign w_rx_next    = {r_rx_shift[SPI_DATA_W-2:0], w_mosi};
    assign w_tx_accept  = i_tx_valid && !r_hold_full;

    // A reload only empties a full register, and a write only fills an empty one, so they never collide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_reload && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (w_tx_accept) begin
            r_hold      <= i_tx_data;
            r_hold_full <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_miso        <= 1'b0;
`ifdef SPI_PERIPHERAL_STATUS_EN
            r_frame_err   <= 1'b0;
            r_tx_underrun <= 1'b0;
`endif
        end else begin
            r_rx_valid    <= 1'b0;
`ifdef SPI_PERIPHERAL_STATUS_EN
            r_frame_err   <= 1'b0;
            r_tx_underrun <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_load_start) begin
                        r_state    <= ACTIVE;
                        r_bit_cnt  <= '0;
                        r_tx_shift <= w_reload_dat;
                        r_miso     <= w_reload_dat[SPI_DATA_W-1];
`ifdef SPI_PERIPHERAL_STATUS_EN
                        r_tx_underrun <= !r_hold_full;
`endif
                    end
                end
                ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                        r_miso  <= 1'b0;
`ifdef SPI_PERIPHERAL_STATUS_EN
                        r_frame_err <= (r_bit_cnt != '0);
`endif
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_next;
                        r_bit_cnt  <= r_bit_cnt + SPI_CNT_W'(1);
                        if (r_bit_cnt == SPI_CNT_W'(SPI_DATA_W - 1)) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (w_load_next) begin
                            r_tx_shift <= w_reload_dat;
                            r_miso     <= w_reload_dat[SPI_DATA_W-1];
`ifdef SPI_PERIPHERAL_STATUS_EN
                            r_tx_underrun <= !r_hold_full;
`endif
                        end else begin
                            r_tx_shift <= {r_tx_shift[SPI_DATA_W-2:0], 1'b0};
                            r_miso     <= r_tx_shift[SPI_DATA_W-2];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_miso        = r_miso;
    assign o_tx_ready    = !r_hold_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_busy        = !w_cs_lvl;
`ifdef SPI_PERIPHERAL_STATUS_EN
    assign o_frame_err   = r_frame_err;
    assign o_tx_underrun = r_tx_underrun;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: bench-side SPI controller (divisor 8) with an rx scoreboard queue.
module tb_spi_peripheral;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_sclk;
    logic       i_cs_n;
    logic       i_mosi;
    logic       o_miso;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_busy;
`ifdef SPI_PERIPHERAL_STATUS_EN
    logic       o_frame_err;
    logic       o_tx_underrun;
    int         n_frame_err = 0;
    int         n_underrun  = 0;
`endif

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    logic [7:0] exp_rx_q[$];

    always #5 i_clk = ~i_clk;

    spi_peripheral #(.SYNC_STAGES(2)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_sclk     (i_sclk),
        .i_cs_n     (i_cs_n),
        .i_mosi     (i_mosi),
        .o_miso     (o_miso),
        .i_tx_data  (i_tx_data),
        .i_tx_valid (i_tx_valid),
        .o_tx_ready (o_tx_ready),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .o_busy     (o_busy)
`ifdef SPI_PERIPHERAL_STATUS_EN
        ,
        .o_frame_err   (o_frame_err),
        .o_tx_underrun (o_tx_underrun)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receive-side scoreboard: every rx_valid pulse must match the oldest queued byte.
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && o_rx_valid === 1'b1) begin
            rx_cnt++;
            if (exp_rx_q.size() == 0) begin
                check("rx_unexpected", 16'(o_rx_data), 16'hFFFF);
            end else begin
                check("rx_data", 16'(o_rx_data), 16'(exp_rx_q.pop_front()));
            end
        end
`ifdef SPI_PERIPHERAL_STATUS_EN
        if (i_rst_n === 1'b1 && o_frame_err === 1'b1)   n_frame_err++;
        if (i_rst_n === 1'b1 && o_tx_underrun === 1'b1) n_underrun++;
`endif
    end

    task automatic clks(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] d);
        int n = 0;
        while (o_tx_ready !== 1'b1 && n < 100) begin
            clks(1);
            n++;
        end
        check("tx_ready_wait", 16'(o_tx_ready), 16'h1);
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        clks(1);
        i_tx_valid = 1'b0;
        check("tx_ready_drop", 16'(o_tx_ready), 16'h0);
    endtask

    task automatic cs_low();
        i_cs_n = 1'b0;
        clks(5);
    endtask

    task automatic cs_high();
        clks(6);
        i_cs_n = 1'b1;
        clks(8);
    endtask

    // Mode 0: drive MOSI on the fall, sample MISO just before the rise.
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            i_mosi = b[7-i];
            clks(4);
            m[7-i] = o_miso;
            i_sclk = 1'b1;
            clks(4);
            i_sclk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] m;
        int         rx_before;
        logic       bad_miso;
        logic       bad_busy;

        i_rst_n    = 1'b0;
        i_sclk     = 1'b0;
        i_cs_n     = 1'b1;
        i_mosi     = 1'b0;
        i_tx_data  = 8'h00;
        i_tx_valid = 1'b0;
        clks(3);
        check("rst_miso",     16'(o_miso),     16'h0);
        check("rst_tx_ready", 16'(o_tx_ready), 16'h1);
        check("rst_rx_data",  16'(o_rx_data),  16'h00);
        check("rst_rx_valid", 16'(o_rx_valid), 16'h0);
        check("rst_busy",     16'(o_busy),     16'h0);
        i_rst_n = 1'b1;
        clks(10);

        // Single byte
        tx_write(8'hA5);
        cs_low();
        check("busy_in_frame", 16'(o_busy), 16'h1);
        check("tx_ready_after_load", 16'(o_tx_ready), 16'h1);
        exp_rx_q.push_back(8'h3C);
        spi_bits(8'h3C, 8, m);
        check("miso_single", 16'(m), 16'hA5);
        cs_high();
        check("rx_data_hold", 16'(o_rx_data), 16'h3C);
        check("rx_count_single", 16'(rx_cnt), 16'd1);
        check("busy_after_frame", 16'(o_busy), 16'h0);

        // Back-to-back bytes
        tx_write(8'h12);
        cs_low();
        tx_write(8'h34);
        exp_rx_q.push_back(8'hF0);
        exp_rx_q.push_back(8'h0F);
        spi_bits(8'hF0, 8, m);
        check("miso_b2b_0", 16'(m), 16'h12);
        spi_bits(8'h0F, 8, m);
        check("miso_b2b_1", 16'(m), 16'h34);
        cs_high();
        check("rx_count_b2b", 16'(rx_cnt), 16'd3);

        // Underrun
`ifdef SPI_PERIPHERAL_STATUS_EN
        n_underrun = 0;
`endif
        cs_low();
        exp_rx_q.push_back(8'h81);
        spi_bits(8'h81, 8, m);
        check("miso_underrun", 16'(m), 16'h00);
        cs_high();
        check("rx_data_underrun", 16'(o_rx_data), 16'h81);
`ifdef SPI_PERIPHERAL_STATUS_EN
        check("underrun_seen", 16'(n_underrun >= 1), 16'h1);
        n_frame_err = 0;
`endif

        // Aborted frame, then a clean byte
        rx_before = rx_cnt;
        cs_low();
        spi_bits(8'hFF, 5, m);
        cs_high();
        check("abort_no_rx", 16'(rx_cnt), 16'(rx_before));
        check("abort_rx_data_kept", 16'(o_rx_data), 16'h81);
`ifdef SPI_PERIPHERAL_STATUS_EN
        check("abort_frame_err", 16'(n_frame_err), 16'd1);
`endif
        cs_low();
        exp_rx_q.push_back(8'h55);
        spi_bits(8'h55, 8, m);
        cs_high();
        check("rx_after_abort", 16'(o_rx_data), 16'h55);

        // Reset mid-frame
        tx_write(8'hFF);
        cs_low();
        tx_write(8'hEE);
        spi_bits(8'hA0, 3, m);
        check("pre_rst_miso_bits", 16'(m[7:5]), 16'h7);
        clks(5);
        check("pre_rst_miso", 16'(o_miso), 16'h1);
        i_rst_n = 1'b0;
        #1;
        check("midrst_miso",     16'(o_miso),     16'h0);
        check("midrst_tx_ready", 16'(o_tx_ready), 16'h1);
        check("midrst_rx_data",  16'(o_rx_data),  16'h00);
        check("midrst_rx_valid", 16'(o_rx_valid), 16'h0);
        check("midrst_busy",     16'(o_busy),     16'h0);
        i_cs_n = 1'b1;
        clks(3);
        i_rst_n = 1'b1;
        clks(10);
        cs_low();
        exp_rx_q.push_back(8'hC3);
        spi_bits(8'hC3, 8, m);
        check("miso_after_rst", 16'(m), 16'h00);
        cs_high();
        check("rx_after_rst", 16'(o_rx_data), 16'hC3);

        // Noise while deselected
        rx_before = rx_cnt;
        bad_miso  = 1'b0;
        bad_busy  = 1'b0;
        for (int t = 0; t < 12; t++) begin
            i_sclk = ~i_sclk;
            i_mosi = 1'($urandom);
            repeat (3) begin
                clks(1);
                if (o_miso !== 1'b0) bad_miso = 1'b1;
                if (o_busy !== 1'b0) bad_busy = 1'b1;
            end
        end
        clks(8);
        check("noise_miso", 16'(bad_miso), 16'h0);
        check("noise_busy", 16'(bad_busy), 16'h0);
        check("noise_no_rx", 16'(rx_cnt), 16'(rx_before));

        check("scoreboard_drained", 16'(exp_rx_q.size()), 16'd0);
        check("rx_total", 16'(rx_cnt), 16'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
